// File: rtl/sfp_i2c_poller.sv
// sfp_i2c_poller: one-byte random-read I2C master for six SFP cages.
// Open-drain outputs; only the latched cage is ever driven.
module sfp_i2c_poller #(
  parameter int CLK_HZ    = 12000000,
  parameter int SCL_HZ    = 100000,
  parameter int NUM_PORTS = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           port,
  input  logic [6:0]           dev_addr,
  input  logic [7:0]           reg_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [7:0]           rd_data,
  output logic [NUM_PORTS-1:0] sfp_scl_oe,
  output logic [NUM_PORTS-1:0] sfp_sda_oe,
  input  logic [NUM_PORTS-1:0] sfp_sda_in
);

  localparam int DIV = CLK_HZ / (4 * SCL_HZ);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_M1 = DW'(DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_WBYTE, S_WACK, S_RSTART,
    S_RBYTE, S_MNACK, S_STOP, S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [DW-1:0]        div_q;
  logic [1:0]           qtr_q;
  logic [2:0]           bit_q;
  logic [1:0]           byte_q;
  logic [2:0]           port_q;
  logic [6:0]           dev_q;
  logic [7:0]           reg_q;
  logic [7:0]           sh_q;
  logic [7:0]           rx_q;
  logic [7:0]           rd_q;
  logic                 err_q;
  logic                 nack_q;
  logic [NUM_PORTS-1:0] sync1_q;
  logic [NUM_PORTS-1:0] sync2_q;

  logic sda_s;
  logic accept;
  logic bad_port;
  logic qtick;
  logic pend;
  logic scl_low;
  logic sda_low;

  assign accept   = start && !busy;
  assign bad_port = int'(port) >= NUM_PORTS;
  assign qtick    = (div_q == DIV_M1);
  assign pend     = qtick && (qtr_q == 2'd3);
  assign err      = err_q;
  assign rd_data  = rd_q;

  always_comb begin
    sda_s = 1'b1;
    for (int i = 0; i < NUM_PORTS; i++)
      if (port_q == 3'(i)) sda_s = sync2_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept)              state_d = bad_port ? S_DONE : S_START;
        else if (state_q == S_DONE) state_d = S_IDLE;
      end
      S_START, S_RSTART: if (pend) state_d = S_WBYTE;
      S_WBYTE: if (pend && bit_q == 3'd7) state_d = S_WACK;
      S_WACK: begin
        if (pend) begin
          if (nack_q)              state_d = S_STOP;
          else if (byte_q == 2'd0) state_d = S_WBYTE;
          else if (byte_q == 2'd1) state_d = S_RSTART;
          else                     state_d = S_RBYTE;
        end
      end
      S_RBYTE: if (pend && bit_q == 3'd7) state_d = S_MNACK;
      S_MNACK: if (pend) state_d = S_STOP;
      S_STOP:  if (pend) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    scl_low = 1'b0;
    sda_low = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: busy = 1'b0;
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      S_START, S_RSTART: begin
        sda_low = qtr_q[1];
        scl_low = (qtr_q == 2'd3);
      end
      S_WBYTE: begin
        sda_low = ~sh_q[7];
        scl_low = (qtr_q == 2'd0) || (qtr_q == 2'd3);
      end
      S_WACK, S_RBYTE, S_MNACK:
        scl_low = (qtr_q == 2'd0) || (qtr_q == 2'd3);
      S_STOP: begin
        sda_low = ~qtr_q[1];
        scl_low = (qtr_q == 2'd0);
      end
      default: busy = 1'b0;
    endcase
  end

  always_comb begin
    sfp_scl_oe = '0;
    sfp_sda_oe = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (busy && port_q == 3'(i)) begin
        sfp_scl_oe[i] = scl_low;
        sfp_sda_oe[i] = sda_low;
      end
  end

  // Datapath: quarter divider, shifters and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      qtr_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      port_q  <= '0;
      dev_q   <= '0;
      reg_q   <= '0;
      sh_q    <= '0;
      rx_q    <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      nack_q  <= 1'b0;
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= sfp_sda_in;
      sync2_q <= sync1_q;
      if (accept) begin
        port_q <= port;
        dev_q  <= dev_addr;
        reg_q  <= reg_addr;
        sh_q   <= {dev_addr, 1'b0};
        div_q  <= '0;
        qtr_q  <= '0;
        bit_q  <= '0;
        byte_q <= '0;
        err_q  <= bad_port;
      end else if (busy) begin
        div_q <= qtick ? '0 : div_q + 1'b1;
        if (qtick) qtr_q <= qtr_q + 2'd1;
        if (qtick && qtr_q == 2'd2) begin
          nack_q <= sda_s;
          if (state_q == S_RBYTE) rx_q <= {rx_q[6:0], sda_s};
        end
        if (pend) begin
          case (state_q)
            S_WBYTE: begin
              sh_q  <= {sh_q[6:0], 1'b0};
              bit_q <= bit_q + 3'd1;
            end
            S_WACK: begin
              byte_q <= byte_q + 2'd1;
              if (nack_q)              err_q <= 1'b1;
              else if (byte_q == 2'd0) sh_q  <= reg_q;
            end
            S_RSTART: sh_q  <= {dev_q, 1'b1};
            S_RBYTE:  bit_q <= bit_q + 3'd1;
            S_MNACK:  rd_q  <= rx_q;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/sfp_i2c_poller.md
# sfp_i2c_poller

Single-engine I2C master that performs one-byte random reads from the management interface of one of the six SFP cages. It sits upstream of the board's I2C slave register file: a host-side sequencer issues read requests, and the returned bytes fill the slave's input registers. The cage SCL/SDA lines are driven open-drain. Only the selected cage is ever driven; all others stay released.

## Interface
- `CLK_HZ`, default 12000000: system clock frequency.
- `SCL_HZ`, default 100000: SCL frequency.
- `NUM_PORTS`, default 6: number of cages.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request pulse; accepted only when `busy`=0.
- `port`  in  3  cage index, sampled on accept.
- `dev_addr`  in  7  I2C device address (0x50 EEPROM, 0x51 DDM), sampled on accept.
- `reg_addr`  in  8  register offset, sampled on accept.
- `busy`  out  1  transaction in progress.
- `done`  out  1  one-cycle pulse at end of transaction.
- `err`  out  1  NACK seen or bad port; valid with `done`, held until next accept.
- `rd_data`  out  8  read byte; valid with `done`, held until next accept.
- `sfp_scl_oe`  out  NUM_PORTS  1 pulls SCL low.
- `sfp_sda_oe`  out  NUM_PORTS  1 pulls SDA low.
- `sfp_sda_in`  in  NUM_PORTS  SDA pad input.

## Operation
- Reset state:
  - All `*_oe` are 0 (released).
  - `busy`, `done` and `err` are 0.
  - `rd_data` is 0x00.
  - FSM is in IDLE.
- Accept: when `start`=1 and `busy`=0, the block latches the request and sets `busy`=1 the next cycle. A `start` while `busy`=1 is ignored.
- Bad port: if `port` >= NUM_PORTS, there is no bus activity. `done`=1 and `err`=1 one cycle after accept, and `busy` returns to 0.
- Sequence: START, `{dev_addr,0}`, ACK, `reg_addr`, ACK, repeated START, `{dev_addr,1}`, ACK, read 8 bits MSB first, master NACK, STOP.
- FSM states: IDLE → START → WBYTE → WACK, looping through WBYTE/WACK for 2 bytes → RSTART → WBYTE → WACK → RBYTE → MNACK → STOP → DONE → IDLE.
- Any WACK sampling SDA=1 sets `err` and jumps to STOP, skipping the remaining phases. `rd_data` is not updated in that case.
- `sfp_sda_in` is passed through a 2-flop synchronizer before sampling. Clock stretching is not supported, and SCL is never sampled.
- Reset mid-transaction:
  - All lines release immediately.
  - The slave may be left mid-byte.
  - The next transaction starts with a normal START; bus recovery is not this block's job.

## Timing
- Quarter tick: DIV = CLK_HZ/(4·SCL_HZ), integer division (30 at default). The divider restarts on accept.
- Every phase is 4 quarters (q0..q3).
- Data/ACK bit:
  - q0: SCL low; SDA set to the bit (oe = ~bit), or released for a slave-driven bit.
  - q1 and q2: SCL released.
  - Sample SDA at the end of q2.
  - q3: SCL low.
- START / RSTART:
  - q0 and q1: SDA and SCL released.
  - q2: SDA low with SCL high.
  - q3: SCL low.
- STOP:
  - q0: SDA low, SCL low.
  - q1: SCL released.
  - q2: SDA released.
  - q3: idle.
- SDA changes only while SCL is low, except in START/RSTART/STOP.
- Full read is 39 phases = 156 quarters. `done` is asserted at accept + 156·DIV + 1 cycles.
- Address NACK is 11 phases (START, 9 bits, STOP) = 44 quarters. `done` is asserted at accept + 44·DIV + 1 cycles.
- `busy` falls in the same cycle `done` is high. A new `start` is accepted in that same cycle.

## Test plan
- Reset released, no `start`:
  - All oe remain 0 for 10000 cycles.
  - `busy` = `done` = 0.
- Port 2, dev 0x50, reg 0x14, slave model ACKs and returns 0xA5:
  - Bytes seen on the bus are 0xA0, 0x14, then 0xA1 after the repeated START.
  - `rd_data` = 0xA5, `err` = 0.
  - `done` at cycle 4681.
  - Ports 0, 1 and 3–5 oe stay 0 throughout.
- Port 0, dev 0x51, no slave present (SDA pulled high):
  - STOP follows the first ACK slot.
  - `err` = 1 and `done` at cycle 1321.
  - `rd_data` is unchanged.
- Slave ACKs the address but NACKs `reg_addr`:
  - STOP follows the second ACK.
  - `err` = 1 and `rd_data` is unchanged.
- `port` = 6:
  - `done` and `err` both 1 on the cycle after accept.
  - No oe toggles.
- `start` pulsed again at accept + 100:
  - The second pulse is ignored.
  - `start` issued in the `done` cycle is accepted, and the next transaction's START begins.
- `rst_n` asserted mid-RBYTE:
  - All oe drop to 0 asynchronously; `busy` = 0.
  - A following transaction completes correctly.
